// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM BIST engine: FSM state encoding,
// the address/seed test pattern and a saturating counter increment.
package ram_bist_pkg;

  // Widest RAM word the engine supports; callers truncate the pattern to their width.
  localparam int MAX_DW = 72;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Pattern word for one address. A unit of addr_w bits is repeated from the LSB
  // upwards and the surplus MSBs are dropped.
  // For addr_w <= 16 the unit is addr XOR seed.
  // For wider addresses the unit is the zero-extended seed.
  // inv selects the complement pattern used by the second pass.
  function automatic logic [MAX_DW-1:0] bist_pattern(input logic [15:0] addr,
                                                     input logic [15:0] seed,
                                                     input int          addr_w,
                                                     input logic        inv);
    logic [15:0]       unit;
    logic [MAX_DW-1:0] word;
    int                j;
    unit = (addr_w <= 16) ? (addr ^ seed) : seed;
    word = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      j = i % addr_w;
      word[i] = (j < 16) ? unit[j[3:0]] : 1'b0;
    end
    return inv ? ~word : word;
  endfunction

  // Increment val, holding once it reaches the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int w);
    logic [31:0] max_v;
    if (w >= 32) max_v = '1;
    else         max_v = (32'd1 << w) - 32'd1;
    return (val == max_v) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ram_bist_sdp_ram.sv
// Inferred simple-dual-port RAM: one write port and one registered read port.
// Read data appears exactly one cycle after i_re. The contents are never reset.
module sdp_ram #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port and registered read port. There is no reset, so the RAM maps to block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_bist.sv
// RAM built-in self-test.
// Each pass writes a seeded pattern to every address, then reads every word back and compares it.
// The engine reports pass/fail, a saturating error count and the first failing address.
// Compare pipeline contract: r_cmp_valid marks the cycle in which w_rdata holds the word
// issued one cycle earlier. r_exp and r_cmp_addr travel alongside it. Nothing is compared
// while r_cmp_valid is low.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int DATA_WIDTH    = 36,
  parameter int ADDR_WIDTH    = 10,
  parameter int NUM_PASSES    = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [15:0]              i_seed,
  input  logic                     i_inj_en,
  input  logic [ADDR_WIDTH-1:0]    i_inj_addr,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_pass,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count,
  output logic                     o_first_err_valid,
  output logic [ADDR_WIDTH-1:0]    o_first_err_addr,
  output bist_state_e              o_state
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic                  LAST_PASS = (NUM_PASSES > 1);

  bist_state_e               r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic                      r_drain;
  logic                      r_pass_idx;
  logic [15:0]               r_seed;
  logic                      r_inj_en;
  logic [ADDR_WIDTH-1:0]     r_inj_addr;
  logic                      r_cmp_valid;
  logic [ADDR_WIDTH-1:0]     r_cmp_addr;
  logic [DATA_WIDTH-1:0]     r_exp;
  logic [ERR_CNT_WIDTH-1:0]  r_err_cnt;
  logic                      r_first_valid;
  logic [ADDR_WIDTH-1:0]     r_first_addr;

  logic                      w_we, w_re, w_start_test, w_more_passes, w_mismatch;
  logic [DATA_WIDTH-1:0]     w_pattern, w_flip, w_wdata, w_rdata;

  assign w_more_passes = (r_pass_idx != LAST_PASS);
  assign w_pattern     = DATA_WIDTH'(bist_pattern(16'(r_addr), r_seed, ADDR_WIDTH, r_pass_idx));
  assign w_wdata       = w_pattern ^ w_flip;
  assign w_mismatch    = (w_rdata != r_exp);

  // Fault injection flips bit 0 of the word written to the latched address.
  always_comb begin
    w_flip    = '0;
    w_flip[0] = r_inj_en && (r_addr == r_inj_addr);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic and per-cycle RAM strobes.
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_re         = 1'b0;
    w_start_test = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_start_test = 1'b1;
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_we = 1'b1;
        if (r_addr == ADDR_LAST) w_state_next = ST_READ;
      end
      ST_READ: begin
        w_re = !r_drain;
        if (r_drain) w_state_next = w_more_passes ? ST_WRITE : ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Address counter, pass index, compare pipeline and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr        <= '0;
      r_drain       <= 1'b0;
      r_pass_idx    <= 1'b0;
      r_seed        <= '0;
      r_inj_en      <= 1'b0;
      r_inj_addr    <= '0;
      r_cmp_valid   <= 1'b0;
      r_cmp_addr    <= '0;
      r_exp         <= '0;
      r_err_cnt     <= '0;
      r_first_valid <= 1'b0;
      r_first_addr  <= '0;
    end else begin
      r_cmp_valid <= w_re;
      if (w_re) begin
        r_cmp_addr <= r_addr;
        r_exp      <= w_pattern;
      end
      if (w_start_test) begin
        r_seed        <= i_seed;
        r_inj_en      <= i_inj_en;
        r_inj_addr    <= i_inj_addr;
        r_addr        <= '0;
        r_drain       <= 1'b0;
        r_pass_idx    <= 1'b0;
        r_err_cnt     <= '0;
        r_first_valid <= 1'b0;
        r_first_addr  <= '0;
      end else begin
        // Writes wrap from the last address back to 0 for the read phase.
        if (w_we) r_addr <= r_addr + 1'b1;
        if (w_re) begin
          if (r_addr == ADDR_LAST) r_drain <= 1'b1;
          else                     r_addr  <= r_addr + 1'b1;
        end
        if (r_state == ST_READ && r_drain) begin
          r_drain <= 1'b0;
          r_addr  <= '0;
          if (w_more_passes) r_pass_idx <= 1'b1;
        end
        if (r_cmp_valid && w_mismatch) begin
          r_err_cnt <= ERR_CNT_WIDTH'(sat_inc(32'(r_err_cnt), ERR_CNT_WIDTH));
          if (!r_first_valid) begin
            r_first_valid <= 1'b1;
            r_first_addr  <= r_cmp_addr;
          end
        end
      end
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  assign o_busy            = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign o_done            = (r_state == ST_DONE);
  assign o_pass            = (r_state == ST_DONE) && (r_err_cnt == '0);
  assign o_err_count       = r_err_cnt;
  assign o_first_err_valid = r_first_valid;
  assign o_first_err_addr  = r_first_addr;
  assign o_state           = r_state;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist.
// dut_a: 16 words x 36 bits, two passes.
// dut_b: single pass.
// dut_c: single pass with a 2-bit error counter.
module tb_ram_bist;
  import ram_bist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] seed = 16'h00A5;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic inj_en_a = 1'b0, inj_en_b = 1'b0, inj_en_c = 1'b0;
  logic [3:0] inj_addr_a = '0, inj_addr_b = '0, inj_addr_c = '0;

  logic busy_a, done_a, pass_a, fv_a; logic [15:0] err_a; logic [3:0] fa_a; bist_state_e st_a;
  logic busy_b, done_b, pass_b, fv_b; logic [15:0] err_b; logic [3:0] fa_b; bist_state_e st_b;
  logic busy_c, done_c, pass_c, fv_c; logic [1:0]  err_c; logic [3:0] fa_c; bist_state_e st_c;

  int n_total = 0;
  int n_bad = 0;
  logic [35:0] bad_word;

  // clock / reset
  always #5 clk = ~clk;

  ram_bist #(.DATA_WIDTH(36), .ADDR_WIDTH(4), .NUM_PASSES(2), .ERR_CNT_WIDTH(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_seed(seed), .i_inj_en(inj_en_a),
    .i_inj_addr(inj_addr_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_err_count(err_a), .o_first_err_valid(fv_a), .o_first_err_addr(fa_a), .o_state(st_a));

  ram_bist #(.DATA_WIDTH(36), .ADDR_WIDTH(4), .NUM_PASSES(1), .ERR_CNT_WIDTH(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_seed(seed), .i_inj_en(inj_en_b),
    .i_inj_addr(inj_addr_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_err_count(err_b), .o_first_err_valid(fv_b), .o_first_err_addr(fa_b), .o_state(st_b));

  ram_bist #(.DATA_WIDTH(36), .ADDR_WIDTH(4), .NUM_PASSES(1), .ERR_CNT_WIDTH(2)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_c), .i_seed(seed), .i_inj_en(inj_en_c),
    .i_inj_addr(inj_addr_c), .o_busy(busy_c), .o_done(done_c), .o_pass(pass_c),
    .o_err_count(err_c), .o_first_err_valid(fv_c), .o_first_err_addr(fa_c), .o_state(st_c));

  // Independent pattern model for seed 0x00A5, 4-bit addresses, first pass.
  function automatic logic [35:0] tb_pat(input logic [3:0] k);
    logic [3:0] u;
    logic [35:0] w;
    u = k ^ 4'h5;
    for (int i = 0; i < 36; i++) w[i] = u[i % 4];
    return w;
  endfunction

  function automatic logic get_busy(input int d);
    case (d) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d) 0: return done_a; 1: return done_b; default: return done_c; endcase
  endfunction

  function automatic bist_state_e get_state(input int d);
    case (d) 0: return st_a; 1: return st_b; default: return st_c; endcase
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d) 0: start_a = v; 1: start_b = v; default: start_c = v; endcase
  endtask

  // Pulse start, then count busy cycles until done (bounded).
  // At busy cycle hit_at, pulse start again and disturb seed/inj_addr.
  task automatic run_count(input int d, input int hit_at, output int n);
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (get_done(d)) break;
      if (get_busy(d)) n++;
      if (n == hit_at) begin
        set_start(d, 1'b1);
        seed = 16'h1234;
        inj_addr_a = 4'd2;
      end else begin
        set_start(d, 1'b0);
      end
      @(negedge clk);
    end
    set_start(d, 1'b0);
  endtask

  task automatic wait_state(input int d, input bist_state_e st, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (get_state(d) == st) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total += 6;
    if (busy_a !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    if (done_a !== 1'b0)    begin n_bad++; $display("FAIL reset_done: got %b want 0", done_a); end
    if (pass_a !== 1'b0)    begin n_bad++; $display("FAIL reset_pass: got %b want 0", pass_a); end
    if (err_a !== 16'd0)    begin n_bad++; $display("FAIL reset_err: got %0d want 0", err_a); end
    if (fv_a !== 1'b0)      begin n_bad++; $display("FAIL reset_fv: got %b want 0", fv_a); end
    if (st_a !== ST_IDLE)   begin n_bad++; $display("FAIL reset_state: got %0d want 0", st_a); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_run();
    int n;
    seed = 16'h00A5; inj_en_a = 1'b0;
    run_count(0, -1, n);
    n_total += 5;
    if (n !== 66)         begin n_bad++; $display("FAIL clean_busy: got %0d want 66", n); end
    if (done_a !== 1'b1)  begin n_bad++; $display("FAIL clean_done: got %b want 1", done_a); end
    if (pass_a !== 1'b1)  begin n_bad++; $display("FAIL clean_pass: got %b want 1", pass_a); end
    if (err_a !== 16'd0)  begin n_bad++; $display("FAIL clean_err: got %0d want 0", err_a); end
    if (fv_a !== 1'b0)    begin n_bad++; $display("FAIL clean_fv: got %b want 0", fv_a); end
  endtask

  task automatic test_inject();
    int n;
    inj_en_a = 1'b1; inj_addr_a = 4'd7;
    run_count(0, -1, n);
    n_total += 6;
    if (n !== 66)         begin n_bad++; $display("FAIL inj_busy: got %0d want 66", n); end
    if (done_a !== 1'b1)  begin n_bad++; $display("FAIL inj_done: got %b want 1", done_a); end
    if (pass_a !== 1'b0)  begin n_bad++; $display("FAIL inj_pass: got %b want 0", pass_a); end
    if (err_a !== 16'd2)  begin n_bad++; $display("FAIL inj_err: got %0d want 2", err_a); end
    if (fv_a !== 1'b1)    begin n_bad++; $display("FAIL inj_fv: got %b want 1", fv_a); end
    if (fa_a !== 4'd7)    begin n_bad++; $display("FAIL inj_faddr: got %0d want 7", fa_a); end
  endtask

  task automatic test_last_addr();
    int n;
    inj_en_b = 1'b1; inj_addr_b = 4'd15;
    run_count(1, -1, n);
    n_total += 5;
    if (n !== 33)         begin n_bad++; $display("FAIL last_busy: got %0d want 33", n); end
    if (done_b !== 1'b1)  begin n_bad++; $display("FAIL last_done: got %b want 1", done_b); end
    if (pass_b !== 1'b0)  begin n_bad++; $display("FAIL last_pass: got %b want 0", pass_b); end
    if (err_b !== 16'd1)  begin n_bad++; $display("FAIL last_err: got %0d want 1", err_b); end
    if (fa_b !== 4'd15)   begin n_bad++; $display("FAIL last_faddr: got %0d want 15", fa_b); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    bit ok;
    inj_en_a = 1'b1; inj_addr_a = 4'd3;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_state(0, ST_READ, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL midrst_reach_read: got 0 want 1"); end
    repeat (10) @(negedge clk);
    n_total += 1;
    if (err_a !== 16'd1) begin n_bad++; $display("FAIL midrst_pre_err: got %0d want 1", err_a); end
    rst_n = 1'b0;
    #1;
    n_total += 6;
    if (busy_a !== 1'b0)  begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
    if (done_a !== 1'b0)  begin n_bad++; $display("FAIL midrst_done: got %b want 0", done_a); end
    if (err_a !== 16'd0)  begin n_bad++; $display("FAIL midrst_err: got %0d want 0", err_a); end
    if (fv_a !== 1'b0)    begin n_bad++; $display("FAIL midrst_fv: got %b want 0", fv_a); end
    if (fa_a !== 4'd0)    begin n_bad++; $display("FAIL midrst_faddr: got %0d want 0", fa_a); end
    if (st_a !== ST_IDLE) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", st_a); end
    @(negedge clk);
    rst_n = 1'b1;
    inj_en_a = 1'b0;
    @(negedge clk);
    run_count(0, -1, n);
    n_total += 3;
    if (n !== 66)         begin n_bad++; $display("FAIL midrst_rerun_busy: got %0d want 66", n); end
    if (pass_a !== 1'b1)  begin n_bad++; $display("FAIL midrst_rerun_pass: got %b want 1", pass_a); end
    if (err_a !== 16'd0)  begin n_bad++; $display("FAIL midrst_rerun_err: got %0d want 0", err_a); end
  endtask

  task automatic test_start_while_busy();
    int n;
    seed = 16'h00A5; inj_en_a = 1'b1; inj_addr_a = 4'd7;
    run_count(0, 10, n);
    n_total += 4;
    if (n !== 66)         begin n_bad++; $display("FAIL busy_start_len: got %0d want 66", n); end
    if (err_a !== 16'd2)  begin n_bad++; $display("FAIL busy_start_err: got %0d want 2", err_a); end
    if (fa_a !== 4'd7)    begin n_bad++; $display("FAIL busy_start_faddr: got %0d want 7", fa_a); end
    if (pass_a !== 1'b0)  begin n_bad++; $display("FAIL busy_start_pass: got %b want 0", pass_a); end
    seed = 16'h00A5; inj_addr_a = 4'd7;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_total += 4;
    if (done_a !== 1'b0)  begin n_bad++; $display("FAIL restart_done: got %b want 0", done_a); end
    if (err_a !== 16'd0)  begin n_bad++; $display("FAIL restart_err: got %0d want 0", err_a); end
    if (fv_a !== 1'b0)    begin n_bad++; $display("FAIL restart_fv: got %b want 0", fv_a); end
    if (busy_a !== 1'b1)  begin n_bad++; $display("FAIL restart_busy: got %b want 1", busy_a); end
    for (int k = 0; k < 200; k++) begin
      if (done_a) break;
      @(negedge clk);
    end
    n_total += 2;
    if (done_a !== 1'b1)  begin n_bad++; $display("FAIL restart_fin_done: got %b want 1", done_a); end
    if (err_a !== 16'd2)  begin n_bad++; $display("FAIL restart_fin_err: got %0d want 2", err_a); end
  endtask

  task automatic test_saturate();
    bit ok;
    logic [3:0] k;
    seed = 16'h00A5; inj_en_c = 1'b0;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    wait_state(2, ST_READ, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL sat_reach_read: got 0 want 1"); end
    // READ cycle c compares the word read for address c-1.
    for (int c = 0; c <= 16; c++) begin
      k = 4'(c - 1);
      if (c >= 1 && (k == 4'd3 || k == 4'd5 || k == 4'd8 || k == 4'd9 || k == 4'd12)) begin
        bad_word = ~tb_pat(k);
        force dut_c.w_rdata = bad_word;
      end else begin
        release dut_c.w_rdata;
      end
      @(negedge clk);
    end
    release dut_c.w_rdata;
    for (int j = 0; j < 50; j++) begin
      if (done_c) break;
      @(negedge clk);
    end
    n_total += 5;
    if (done_c !== 1'b1)  begin n_bad++; $display("FAIL sat_done: got %b want 1", done_c); end
    if (err_c !== 2'd3)   begin n_bad++; $display("FAIL sat_err: got %0d want 3", err_c); end
    if (fv_c !== 1'b1)    begin n_bad++; $display("FAIL sat_fv: got %b want 1", fv_c); end
    if (fa_c !== 4'd3)    begin n_bad++; $display("FAIL sat_faddr: got %0d want 3", fa_c); end
    if (pass_c !== 1'b0)  begin n_bad++; $display("FAIL sat_pass: got %b want 0", pass_c); end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_inject();
    test_last_addr();
    test_reset_mid_read();
    test_start_while_busy();
    test_saturate();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
